peri_irq_ctrl: RTL

Interrupt controller that consumes the peripheral interrupt lines (UART, SPI, MAC) produced by the peripheral subsystem. It raises a single external interrupt towards the CPU. Each source gets:
- a gateway (level or edge),
- a pending bit, an enable bit and a priority.

The CPU uses claim/complete accesses over APB. The block sits on the same APB fabric as the peripherals, beside the peripheral subsystem, and is wired between its IRQ outputs and the core's external-interrupt input.

---
 rtl/peri_irq_pkg.sv | 30 +++
 rtl/peri_irq_ctrl_if.sv | 22 ++
 rtl/peri_irq_gateway.sv | 41 ++++
 rtl/peri_irq_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/peri_irq_pkg.sv
// Shared constants for the peripheral interrupt controller: register
// offsets, ID sizing and the index-to-ID mapping.
package peri_irq_pkg;

  localparam int N_SRC_MAX = 31;
  localparam int ID_W      = 5;

  localparam logic [11:0] OFF_PENDING   = 12'h000;
  localparam logic [11:0] OFF_ENABLE    = 12'h004;
  localparam logic [11:0] OFF_TRIGGER   = 12'h008;
  localparam logic [11:0] OFF_THRESHOLD = 12'h00C;
  localparam logic [11:0] OFF_CLAIM     = 12'h010;
  localparam logic [11:0] OFF_PRIO_BASE = 12'h020;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PENDING,
    REG_ENABLE,
    REG_TRIGGER,
    REG_THRESHOLD,
    REG_CLAIM,
    REG_PRIO
  } reg_sel_e;

  // Source index i is reported to software as ID i+1; ID 0 means "nothing".
  function automatic logic [ID_W-1:0] src_id(input int idx);
    return ID_W'(idx + 1);
  endfunction

endpackage

// File: rtl/peri_irq_ctrl_if.sv
// APB register-access bundle shared by the CPU side (master) and the
// interrupt controller (slave).
interface apb_intf;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/peri_irq_gateway.sv
// Per-source gateway: qualifies the raw line as level or rising edge and
// tracks pending / in-service. Events seen while pending or in service are
// dropped; a claim in the same cycle as a new event wins.
module peri_irq_gateway (
  input  logic clk,
  input  logic rst,
  input  logic src_irq,
  input  logic trigger,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic src_d;
  logic in_service;
  logic set;

  assign set = trigger ? (src_irq & ~src_d) : src_irq;

  // Line history plus pending / in-service bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_d      <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      src_d <= src_irq;
      // set is judged against the current in_service, so a complete in the
      // same cycle still blocks it; a level line re-pends one cycle later.
      if (claim)
        pending <= 1'b0;
      else if (set && !in_service)
        pending <= 1'b1;
      if (claim)
        in_service <= 1'b1;
      else if (complete)
        in_service <= 1'b0;
    end
  end

endmodule

// File: rtl/peri_irq_ctrl.sv
// Peripheral interrupt controller: APB register file, per-source gateways,
// priority arbiter and the registered external interrupt to the CPU.
module peri_irq_ctrl
  import peri_irq_pkg::*;
#(
  parameter int unsigned N_SRC  = 3,
  parameter int unsigned PRIO_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  apb_intf.slave           s_apb_intf,
  input  logic [N_SRC-1:0] src_irq,
  output logic             irq_out
);

  logic              access;
  logic              wr_en;
  logic              rd_en;
  reg_sel_e          reg_sel;
  logic [N_SRC-1:0]  prio_hit;

  logic [N_SRC-1:0]  enable_r;
  logic [N_SRC-1:0]  trigger_r;
  logic [PRIO_W-1:0] threshold_r;
  logic [PRIO_W-1:0] prio_r [N_SRC];

  logic [N_SRC-1:0]  pending;
  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;

  logic              claim_hit;
  logic              complete_hit;
  logic [N_SRC-1:0]  claim_vec;
  logic [N_SRC-1:0]  complete_vec;
  logic [31:0]       rdata;
  logic              unused_pwdata;

  assign access = s_apb_intf.psel & s_apb_intf.penable;
  assign wr_en  = access & s_apb_intf.pwrite;
  assign rd_en  = access & ~s_apb_intf.pwrite;

  // Only the low bits of pwdata carry fields; the rest are don't-care.
  assign unused_pwdata = ^s_apb_intf.pwdata;

  // Address decode; anything not matched stays REG_NONE and errors.
  always_comb begin
    reg_sel  = REG_NONE;
    prio_hit = '0;
    case (s_apb_intf.paddr)
      OFF_PENDING:   reg_sel = REG_PENDING;
      OFF_ENABLE:    reg_sel = REG_ENABLE;
      OFF_TRIGGER:   reg_sel = REG_TRIGGER;
      OFF_THRESHOLD: reg_sel = REG_THRESHOLD;
      OFF_CLAIM:     reg_sel = REG_CLAIM;
      default:       ;
    endcase
    for (int i = 0; i < N_SRC; i++) begin
      if (s_apb_intf.paddr == OFF_PRIO_BASE + 12'(4 * i)) begin
        prio_hit[i] = 1'b1;
        reg_sel     = REG_PRIO;
      end
    end
  end

  // Configuration registers, written at the edge that ends the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_r    <= '0;
      trigger_r   <= '0;
      threshold_r <= '0;
      for (int i = 0; i < N_SRC; i++) prio_r[i] <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_ENABLE:    enable_r    <= s_apb_intf.pwdata[N_SRC-1:0];
        REG_TRIGGER:   trigger_r   <= s_apb_intf.pwdata[N_SRC-1:0];
        REG_THRESHOLD: threshold_r <= s_apb_intf.pwdata[PRIO_W-1:0];
        REG_PRIO: begin
          for (int i = 0; i < N_SRC; i++)
            if (prio_hit[i]) prio_r[i] <= s_apb_intf.pwdata[PRIO_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Highest-priority eligible source; strict '>' keeps the lowest index on
  // ties. Eligible sources always have prio > 0, so best_prio=0 means empty.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pending[i] && enable_r[i] && (prio_r[i] > threshold_r) &&
          (prio_r[i] > best_prio)) begin
        best_id   = src_id(i);
        best_prio = prio_r[i];
      end
    end
  end

  assign claim_hit    = rd_en && (reg_sel == REG_CLAIM) && (best_id != '0);
  assign complete_hit = wr_en && (reg_sel == REG_CLAIM);

  // One-hot claim/complete strobes; IDs outside 1..N_SRC match nothing.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_vec[i]    = claim_hit && (best_id == src_id(i));
      complete_vec[i] = complete_hit && (s_apb_intf.pwdata[ID_W-1:0] == src_id(i));
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_gw
    peri_irq_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .src_irq  (src_irq[g]),
      .trigger  (trigger_r[g]),
      .claim    (claim_vec[g]),
      .complete (complete_vec[g]),
      .pending  (pending[g])
    );
  end

  // Read mux; unmapped offsets read 0.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_PENDING:   rdata = 32'(pending);
      REG_ENABLE:    rdata = 32'(enable_r);
      REG_TRIGGER:   rdata = 32'(trigger_r);
      REG_THRESHOLD: rdata = 32'(threshold_r);
      REG_CLAIM:     rdata = 32'(best_id);
      REG_PRIO: begin
        for (int i = 0; i < N_SRC; i++)
          if (prio_hit[i]) rdata = 32'(prio_r[i]);
      end
      default: ;
    endcase
  end

  assign s_apb_intf.prdata  = rd_en ? rdata : 32'h0;
  assign s_apb_intf.pslverr = access && (reg_sel == REG_NONE);
  assign s_apb_intf.pready  = 1'b1;

  // Registered external interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_out <= 1'b0;
    else     irq_out <= (best_id != '0);
  end

endmodule
